// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM link types and default constants
package pwm_pkg;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

    localparam int PWM_DATA_WIDTH    = 12;
    localparam int PWM_COUNTER_WIDTH = 10;
    localparam int PWM_OFFSET        = 512;

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - PWM input synchronizer with rising-edge detect
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_pwm,
    output logic o_pwm_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_pwm_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pwm_s = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_pwm_d;

endmodule

// File: rtl/pwm_demod.sv
// rtl/pwm_demod.sv - frame-locked PWM demodulator recovering one data word per frame
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int DATA_WIDTH    = PWM_DATA_WIDTH,
    parameter int COUNTER_WIDTH = PWM_COUNTER_WIDTH,
    parameter int OFFSET        = PWM_OFFSET,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  PWMIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  Locked,
    output logic                  PeriodErr
);

    localparam int CW = COUNTER_WIDTH + 1;
    localparam int EW = (DATA_WIDTH > CW) ? DATA_WIDTH : CW;
    localparam logic [CW-1:0] P = {1'b1, {COUNTER_WIDTH{1'b0}}};

    logic                  w_pwm_s;
    logic                  w_rise;
    logic                  w_frame_end;
    logic                  w_restart;
    logic [EW-1:0]         w_diff;

    pwm_state_e            r_state, w_state_nx;
    logic [CW-1:0]         r_pcnt, w_pcnt_nx;
    logic [CW-1:0]         r_hcnt, w_hcnt_nx;
    logic [DATA_WIDTH-1:0] r_data, w_data_nx;
    logic                  r_valid, w_valid_nx;
    logic                  r_locked, w_locked_nx;
    logic                  r_perr, w_perr_nx;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_pwm   (PWMIn),
        .o_pwm_s (w_pwm_s),
        .o_rise  (w_rise)
    );

    assign w_frame_end = (r_pcnt == P);
    // Offset removal wraps modulo 2^DATA_WIDTH; hcnt is zero-extended first
    assign w_diff      = EW'(r_hcnt) - EW'(OFFSET);

    always_comb begin
        w_state_nx  = r_state;
        w_pcnt_nx   = r_pcnt;
        w_hcnt_nx   = r_hcnt;
        w_data_nx   = r_data;
        w_valid_nx  = 1'b0;
        w_locked_nx = r_locked;
        w_perr_nx   = 1'b0;
        w_restart   = 1'b0;

        case (r_state)
            SEARCH: begin
                if (w_rise) begin
                    w_restart  = 1'b1;
                    w_state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_restart = 1'b1;
                    if (w_frame_end) begin
                        w_data_nx   = w_diff[DATA_WIDTH-1:0];
                        w_valid_nx  = 1'b1;
                        w_locked_nx = 1'b1;
                    end else begin
                        w_perr_nx   = 1'b1;
                        w_locked_nx = 1'b0;
                    end
                end else if (w_frame_end) begin
                    // Flat frame: while locked, keep frame phase by closing it here
                    if (r_locked) begin
                        w_data_nx  = w_diff[DATA_WIDTH-1:0];
                        w_valid_nx = 1'b1;
                        w_restart  = 1'b1;
                    end else begin
                        w_pcnt_nx  = '0;
                        w_hcnt_nx  = '0;
                        w_state_nx = SEARCH;
                    end
                end else begin
                    w_pcnt_nx = r_pcnt + CW'(1);
                    w_hcnt_nx = r_hcnt + CW'(w_pwm_s);
                end
            end
            default: begin
                w_state_nx = SEARCH;
            end
        endcase

        if (w_restart) begin
            w_pcnt_nx = CW'(1);
            w_hcnt_nx = CW'(w_pwm_s);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= SEARCH;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pcnt   <= w_pcnt_nx;
            r_hcnt   <= w_hcnt_nx;
            r_data   <= w_data_nx;
            r_valid  <= w_valid_nx;
            r_locked <= w_locked_nx;
            r_perr   <= w_perr_nx;
        end
    end

    assign DataOut   = r_data;
    assign DataValid = r_valid;
    assign Locked    = r_locked;
    assign PeriodErr = r_perr;

endmodule

// File: tb/tb_pwm_demod.sv
// tb/tb_pwm_demod.sv - loopback bench for pwm_demod with a behavioural PWM generator
module tb_pwm_demod;

    localparam int DW  = 12;
    localparam int CW  = 10;
    localparam int P   = 1024;
    localparam int OFF = 512;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          PWMIn = 1'b0;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          Locked;
    logic          PeriodErr;

    pwm_demod #(
        .DATA_WIDTH    (DW),
        .COUNTER_WIDTH (CW),
        .OFFSET        (OFF),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .PWMIn     (PWMIn),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .Locked    (Locked),
        .PeriodErr (PeriodErr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int mon_cyc  = 0;
    int dv_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;
    int last_dv  = -1;
    int rel_cyc  = -1;
    int first_dv_rel = -1;
    int last_d   = 0;
    bit locked_seen = 1'b0;
    bit spc_en   = 1'b0;
    logic rstn_prev = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        int e;
        mon_cyc++;
        if (rstn && !rstn_prev) begin
            rel_cyc      = mon_cyc;
            first_dv_rel = -1;
        end
        rstn_prev = rstn;
        if (DataValid && PeriodErr) both_cnt++;
        if (Locked) locked_seen = 1'b1;
        if (PeriodErr) pe_cnt++;
        if (DataValid) begin
            dv_cnt++;
            if (first_dv_rel < 0) first_dv_rel = mon_cyc;
            chk("dv_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dataout", int'(DataOut), e);
            end
            if (spc_en && last_dv >= 0) chk("dv_spacing", mon_cyc - last_dv, P);
            last_dv = mon_cyc;
        end
    end

    task automatic tick(input bit v);
        @(posedge clk);
        #1;
        PWMIn = v;
    endtask

    // One generator frame of word d; emit_prev queues the word of the frame it closes
    task automatic frame(input int d, input bit emit_prev, input int glitch_at, input int rst_at);
        int duty;
        bit v;
        duty = (d + OFF) % P;
        if (emit_prev) exp_q.push_back(last_d);
        for (int c = 0; c < P; c++) begin
            v = (c < duty);
            if (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 3) v = 1'b1;
            tick(v);
            if (c == rst_at) begin
                rstn = 1'b0;
                #1;
                chk("midrst_dataout", int'(DataOut), 0);
                chk("midrst_valid", int'(DataValid), 0);
                chk("midrst_locked", int'(Locked), 0);
                chk("midrst_perr", int'(PeriodErr), 0);
            end
            if (rst_at >= 0 && c == rst_at + 5) rstn = 1'b1;
        end
        last_d = d & ((1 << DW) - 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        PWMIn = 1'b0;
        rstn  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
    endtask

    initial begin
        int pe0;
        int dv0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataout", int'(DataOut), 0);
        chk("rst_valid", int'(DataValid), 0);
        chk("rst_locked", int'(Locked), 0);
        chk("rst_perr", int'(PeriodErr), 0);
        rstn = 1'b1;
        repeat (4) tick(1'b0);

        // Lock at 100, one word per frame
        spc_en  = 1'b1;
        last_dv = -1;
        frame(100, 1'b0, -1, -1);
        repeat (3) frame(100, 1'b1, -1, -1);
        chk("t1_locked", int'(Locked), 1);

        // Flat-low frames while locked at 5
        frame(5, 1'b1, -1, -1);
        frame(5, 1'b1, -1, -1);
        frame('hE00, 1'b1, -1, -1);
        frame('hE00, 1'b1, -1, -1);
        chk("t2_locked_flat", int'(Locked), 1);
        frame('hE00, 1'b1, -1, -1);
        frame(5, 1'b1, -1, -1);
        frame(5, 1'b1, -1, -1);
        chk("t2_queue_drained", exp_q.size(), 0);

        // Step 511 -> -512 -> 0
        pe0 = pe_cnt;
        dv0 = dv_cnt;
        frame(511, 1'b1, -1, -1);
        frame(511, 1'b1, -1, -1);
        frame('hE00, 1'b1, -1, -1);
        frame('hE00, 1'b1, -1, -1);
        frame(0, 1'b1, -1, -1);
        frame(0, 1'b1, -1, -1);
        frame(0, 1'b1, -1, -1);
        chk("t3_no_perr", pe_cnt - pe0, 0);
        chk("t3_dv_count", dv_cnt - dv0, 7);
        spc_en = 1'b0;

        // 3-clock glitch inside a low frame while locked
        pe0 = pe_cnt;
        dv0 = dv_cnt;
        frame('hE00, 1'b1, -1, -1);
        frame('hE00, 1'b1, 500, -1);
        frame('hE00, 1'b0, -1, -1);
        chk("t4_perr_once", pe_cnt - pe0, 1);
        chk("t4_unlocked", int'(Locked), 0);
        frame(5, 1'b0, -1, -1);
        frame(5, 1'b1, -1, -1);
        chk("t4_relocked", int'(Locked), 1);
        chk("t4_dv_count", dv_cnt - dv0, 3);

        // Reset mid-frame, in the low phase
        pe0 = pe_cnt;
        frame(5, 1'b1, -1, 700);
        frame(5, 1'b0, -1, -1);
        chk("t5_unlocked_after_rst", int'(Locked), 0);
        frame(5, 1'b1, -1, -1);
        chk("t5_first_dv_delay", first_dv_rel - rel_cyc, (P - 705) + P + SS + 1);
        chk("t5_relocked", int'(Locked), 1);
        chk("t5_no_perr", pe_cnt - pe0, 0);

        // Free-running 1000-clock square wave
        do_reset(3);
        pe0 = pe_cnt;
        dv0 = dv_cnt;
        locked_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 1000; c++) tick(c < 500);
        end
        repeat (2100) tick(1'b0);
        chk("t6_perr_count", pe_cnt - pe0, 7);
        chk("t6_never_locked", int'(locked_seen), 0);
        chk("t6_no_dv", dv_cnt - dv0, 0);

        chk("dv_perr_exclusive", both_cnt, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Receive-side counterpart of the team's PWM generator: it recovers the data word carried by a frame-periodic PWM stream. Each frame is 2^COUNTER_WIDTH clocks long, and its high time encodes (data + OFFSET) mod 2^COUNTER_WIDTH. The block synchronizes the input, locks to the frame boundary (rising edge) and counts high cycles per frame. For each good frame it emits a one-cycle-strobed data word with OFFSET removed. It sits in loopback and test benches and on board inputs that accept PWM-encoded samples.

## Interface
- DATA_WIDTH, 12, width of the recovered data word.
- COUNTER_WIDTH, 10, frame length is P = 2^COUNTER_WIDTH clocks.
- OFFSET, 512, subtracted from the measured high count.
- SYNC_STAGES, 2, input synchronizer depth (≥2).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- PWMIn  in  1  PWM stream, asynchronous to clk.
- DataOut  out  DATA_WIDTH  recovered word, held between updates.
- DataValid  out  1  one-cycle strobe; DataOut updated in the same cycle.
- Locked  out  1  high while frames arrive with period P.
- PeriodErr  out  1  one-cycle strobe on a rising edge arriving before P clocks.

## Operation
- Synchronizer: SYNC_STAGES flops give pwm_s; pwm_d is pwm_s delayed by 1. The flops reset to 0.
- rise = pwm_s & ~pwm_d, combinational.
- Counters:
  - pcnt and hcnt are each COUNTER_WIDTH+1 bits wide.
  - On a restart, pcnt is set to 1 and hcnt is set to pwm_s.
  - On every other cycle, pcnt increments and hcnt adds pwm_s.
  - At any cycle, pcnt holds the number of cycles since the last restart. hcnt holds the high cycles in that window, excluding the current cycle.
- States: SEARCH (reset) and MEASURE.
- SEARCH: the counters are idle. On rise, restart and go to MEASURE.
- In MEASURE, every rise is evaluated as follows:
  - If pcnt == P (good frame): DataOut <= (hcnt − OFFSET) mod 2^DATA_WIDTH, with hcnt zero-extended. Pulse DataValid, set Locked to 1, restart.
  - If pcnt < P: pulse PeriodErr, clear Locked, restart. DataOut is unchanged and there is no DataValid.
- MEASURE, timeout (pcnt == P and no rise):
  - This handles flat frames, e.g. 0 % duty.
  - If Locked: treat the cycle as a frame boundary. Emit DataOut/DataValid from hcnt as for a good frame, then restart. This preserves the frame phase.
  - If not Locked: clear the counters and return to SEARCH.
- Arithmetic: subtraction wraps modulo 2^DATA_WIDTH. For a generator word D with D+OFFSET in [0, P−1], the round trip is exact. A constant-high frame gives hcnt = P and is reported unclamped.
- Reset mid-frame: all state is cleared asynchronously. The next frame is found through SEARCH; a partial frame never produces DataValid.

## Timing
- Reset values: DataOut = 0, DataValid = 0, Locked = 0, PeriodErr = 0, state SEARCH.
- A PWMIn edge appears on pwm_s after SYNC_STAGES clocks.
- DataValid, PeriodErr and the Locked update are registered. They appear SYNC_STAGES+1 clocks after the PWMIn rising edge that closes the frame.
- First DataValid after reset or loss of lock: at the close of the first complete P-clock frame after the first detected rise. This is about 2P clocks worst case.
- Throughput: one word per P clocks while locked.
- Simultaneous events: a rise exactly at pcnt == P is a good frame, never a timeout. DataValid and PeriodErr are never high together.
- Glitch or extra edge inside a frame: PeriodErr, loss of lock and re-measurement from that edge. The next full-period frame relocks with DataValid.

## Structure
- Shared package pwm_pkg:
  - State enum {SEARCH, MEASURE}.
  - Default constants for DATA_WIDTH, COUNTER_WIDTH and OFFSET, also used by the generator.
- Sub-module pwm_sync_edge: SYNC_STAGES synchronizer plus rise detect. Outputs pwm_s and rise.

## Test plan
- Generator→demod loopback, DataIn = 100 (OFFSET 512): first DataValid gives DataOut = 100, Locked = 1, then one DataValid every 1024 clocks.
- DataIn = 0xE00 (−512, so the line is flat low) after lock at DataIn = 5: DataOut becomes 0xE00 on timeout frames, Locked stays 1, and the first word after DataIn returns to 5 is exactly 5.
- DataIn stepped 511 → −512 → 0: each value is recovered exactly with no PeriodErr. Check the DataValid spacing is exactly 1024.
- A 3-clock glitch high injected mid-low-phase while locked: one PeriodErr strobe, Locked = 0, no DataValid for the disturbed frame, relock with a correct word on the next clean frame.
- rstn asserted for 5 clocks mid-frame: all outputs 0 immediately; the first DataValid after release is correct and comes only after a full frame.
- Free-running 1000-clock-period square wave: PeriodErr on every rise, Locked never 1, no DataValid.
